// File: rtl/mmio_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_console_if
//  Purpose  : Core data-bus view of the console/halt peripheral. The core
//             drives address, store data and the store strobe. The peripheral
//             returns a combinational select and read data.
//  Revision : 1.0  initial release
// ============================================================================
interface mmio_console_if;
    logic [31:0] memory_address;
    logic [31:0] memory_data_out;
    logic        memory_write_enable;
    logic        mmio_select;
    logic [31:0] mmio_data_in;

    // Core side of the bus.
    modport master (
        output memory_address,
        output memory_data_out,
        output memory_write_enable,
        input  mmio_select,
        input  mmio_data_in
    );

    // Peripheral side of the bus.
    modport slave (
        input  memory_address,
        input  memory_data_out,
        input  memory_write_enable,
        output mmio_select,
        output mmio_data_in
    );
endinterface
`default_nettype wire

// File: rtl/mmio_console.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_console
//  Purpose  : Memory-mapped console and halt peripheral. Stores to TXDATA are
//             buffered in a TX FIFO and sent out as UART 8N1 frames. A store
//             to the halt address latches a sticky halt and an exit code.
//             STATUS is read combinationally, with zero wait states.
//  Revision : 1.0  initial release
// ============================================================================
module mmio_console #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0800,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0FFC,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    mmio_console_if.slave  bus,
    output logic           uart_tx,
    output logic           halt,
    output logic [7:0]     exit_code
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST   = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_DEPTH       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]         c_STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [29:0]         c_TXDATA_WORD = BASE_ADDR[31:2];
    localparam logic [29:0]         c_STATUS_WORD = c_STATUS_ADDR[31:2];
    localparam logic [29:0]         c_HALT_WORD   = HALT_ADDR[31:2];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Address decode (word granular, byte offset ignored)
    // ------------------------------------------------------------------
    logic [29:0] w_word;
    logic        w_hit_tx;
    logic        w_hit_status;
    logic        w_hit_halt;
    logic        w_unused;

    assign w_word       = bus.memory_address[31:2];
    assign w_hit_tx     = (w_word == c_TXDATA_WORD);
    assign w_hit_status = (w_word == c_STATUS_WORD);
    assign w_hit_halt   = (w_word == c_HALT_WORD);

    // Address byte offset and upper store data never influence the peripheral.
    assign w_unused = &{1'b0, bus.memory_address[1:0], bus.memory_data_out[31:8]};

    // ------------------------------------------------------------------
    // TX FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic               w_empty;
    logic               w_full;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_ovf_set;
    logic               w_ovf_clr;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_DEPTH);
    assign w_push_req = bus.memory_write_enable & w_hit_tx;
    // A full FIFO still takes the byte if the head leaves on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & ~w_push;
    assign w_ovf_clr  = bus.memory_write_enable & w_hit_status & bus.memory_data_out[3];

    // Byte storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.memory_data_out[7:0];
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; set and clear come from different addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Halt latch
    // ------------------------------------------------------------------
    logic       r_halt;
    logic [7:0] r_exit_code;

    // Only the first halt store after reset is recorded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halt      <= 1'b0;
            r_exit_code <= 8'd0;
        end else if (bus.memory_write_enable && w_hit_halt && !r_halt) begin
            r_halt      <= 1'b1;
            r_exit_code <= bus.memory_data_out[7:0];
        end
    end

    assign halt      = r_halt;
    assign exit_code = r_exit_code;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                w_tx_cur;
    logic                w_baud_end;
    logic                r_tx;

    assign w_baud_end = (r_baud == c_BAUD_LAST);

    // FSM state, baud counter, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic, FIFO pop request and line level for the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_cur    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_cur = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_START: begin
                w_tx_cur = 1'b0;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            S_DATA: begin
                w_tx_cur = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            S_STOP: begin
                w_tx_cur = 1'b1;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + c_BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered line driver: glitch-free output, one clock behind the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_cur;
        end
    end

    assign uart_tx = r_tx;

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    logic [4:0]  w_count_ext;
    logic        w_busy;
    logic [31:0] w_status;

    assign w_count_ext = 5'(r_count);
    assign w_busy      = (r_state != S_IDLE);
    assign w_status    = {23'd0, w_count_ext, r_ovf, w_busy, w_full, w_empty};

    assign bus.mmio_select  = w_hit_tx | w_hit_status;
    assign bus.mmio_data_in = w_hit_status ? w_status : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mmio_console.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_console
//  Purpose  : Self-checking bench for mmio_console. A behavioural model keeps
//             the TX buffer as a queue and the transmitter as a busy-cycle
//             count. Expected bus responses and expected UART frames are queued
//             and consumed by independent monitors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_console;

    localparam logic [31:0] BASE  = 32'h0000_0800;
    localparam logic [31:0] STATA = 32'h0000_0804;
    localparam logic [31:0] HALTA = 32'h0000_0FFC;
    localparam int          DEPTH = 8;
    localparam int          CPB   = 4;

    logic       clk   = 1'b1;
    logic       reset = 1'b0;
    logic       uart_tx;
    logic       halt;
    logic [7:0] exit_code;

    mmio_console_if bus();

    mmio_console #(
        .BASE_ADDR    (BASE),
        .HALT_ADDR    (HALTA),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .uart_tx   (uart_tx),
        .halt      (halt),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    typedef struct {
        logic        sel;
        logic [31:0] rdata;
        logic        halt;
        logic [7:0]  code;
    } cyc_t;

    logic [7:0] m_q[$];
    int         m_busy;
    logic       m_ovf;
    logic       m_halt;
    logic [7:0] m_exit;
    int         cyc = 0;
    frame_t     exp_frames[$];
    cyc_t       exp_cyc[$];

    // 0 none, 1 TXDATA, 2 STATUS, 3 HALT
    function automatic int kind(input logic [31:0] addr);
        if (addr[31:2] == BASE[31:2])  return 1;
        if (addr[31:2] == STATA[31:2]) return 2;
        if (addr[31:2] == HALTA[31:2]) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = 32'd0;
        s[0]   = (m_q.size() == 0);
        s[1]   = (m_q.size() == DEPTH);
        s[2]   = (m_busy > 0);
        s[3]   = m_ovf;
        s[8:4] = 5'(m_q.size());
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_ovf  = 1'b0;
        m_halt = 1'b0;
        m_exit = 8'd0;
        exp_frames.delete();
        exp_cyc.delete();
    endtask

    task automatic push_expect(input logic [31:0] addr);
        cyc_t e;
        int   k;
        k       = kind(addr);
        e.sel   = (k == 1) || (k == 2);
        e.rdata = (k == 2) ? m_status() : 32'd0;
        e.halt  = m_halt;
        e.code  = m_exit;
        exp_cyc.push_back(e);
    endtask

    // Advance the model across one rising edge with the inputs of that cycle.
    task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] data);
        int     pre;
        bit     pop;
        frame_t f;
        cyc++;
        if (reset) return;
        pre = m_q.size();
        pop = (m_busy == 0) && (pre > 0);
        if (pop) begin
            f.b     = m_q.pop_front();
            f.start = cyc + 1;
            exp_frames.push_back(f);
            m_busy  = 10 * CPB;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        if (we) begin
            case (kind(addr))
                1: if (pre < DEPTH || pop) m_q.push_back(data[7:0]); else m_ovf = 1'b1;
                2: if (data[3]) m_ovf = 1'b0;
                3: if (!m_halt) begin m_halt = 1'b1; m_exit = data[7:0]; end
                default: ;
            endcase
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.memory_write_enable = we;
        bus.memory_address      = addr;
        bus.memory_data_out     = data;
        push_expect(addr);
        @(posedge clk);
        model_step(we, addr, data);
        #1;
    endtask

    task automatic peek_status(output logic [31:0] v);
        bus.memory_write_enable = 1'b0;
        bus.memory_address      = STATA;
        #1;
        v = bus.mmio_data_in;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_q.size() > 0 || m_busy > 0 || exp_frames.size() > 0) && guard < 3000) begin
            step(1'b0, STATA, 32'd0);
            guard++;
        end
        check("drain_timeout", 32'(guard < 3000), 32'd1);
        repeat (2) step(1'b0, STATA, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Bus / halt monitor: one expected response per cycle
    // ------------------------------------------------------------------
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (exp_cyc.size() > 0) begin
                e = exp_cyc.pop_front();
                check("mmio_select",  32'(bus.mmio_select), 32'(e.sel));
                check("mmio_data_in", bus.mmio_data_in,     e.rdata);
                check("halt",         32'(halt),            32'(e.halt));
                check("exit_code",    32'(exit_code),       32'(e.code));
            end
        end
    end

    // ------------------------------------------------------------------
    // UART receiver monitor: mid-bit sampling, frame data and start time
    // ------------------------------------------------------------------
    initial begin
        bit         active;
        int         n;
        int         k;
        int         idx;
        int         st;
        logic [7:0] sh;
        frame_t     f;
        active = 0;
        n      = 0;
        st     = 0;
        sh     = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
                continue;
            end
            if (!active) begin
                if (uart_tx === 1'b0) begin
                    active = 1;
                    n      = 0;
                    st     = cyc;
                end
            end else begin
                n++;
            end
            if (active) begin
                k = n - CPB / 2;
                if (k >= 0 && (k % CPB) == 0) begin
                    idx = k / CPB;
                    if (idx == 0) begin
                        check("start_bit", 32'(uart_tx), 32'd0);
                    end else if (idx <= 8) begin
                        sh[idx-1] = uart_tx;
                    end else begin
                        check("stop_bit", 32'(uart_tx), 32'd1);
                        if (exp_frames.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", sh);
                        end else begin
                            f = exp_frames.pop_front();
                            check("frame_data",  32'(sh), 32'(f.b));
                            check("frame_start", 32'(st), 32'(f.start));
                        end
                        active = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        int          r;
        int          guard;

        bus.memory_write_enable = 1'b0;
        bus.memory_address      = 32'd0;
        bus.memory_data_out     = 32'd0;
        model_reset();
        #1 reset = 1'b1;

        // Reset state
        step(1'b0, STATA, 32'd0);
        step(1'b0, STATA, 32'd0);
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_halt",    32'(halt),    32'd0);
        peek_status(v);
        check("reset_status", v, 32'h0000_0001);
        reset = 1'b0;

        // Single byte 0x41
        step(1'b1, BASE, 32'h0000_0041);
        step(1'b0, STATA, 32'd0);
        peek_status(v);
        check("t1_busy", 32'(v[2]), 32'd1);
        repeat (44) step(1'b0, STATA, 32'd0);
        peek_status(v);
        check("t1_idle_empty", v, 32'h0000_0001);

        // Ten back-to-back stores: fill, then one dropped
        for (int i = 0; i < 10; i++) step(1'b1, BASE, 32'h30 + 32'(i));
        peek_status(v);
        check("t2_count", 32'(v[8:4]), 32'd8);
        check("t2_full",  32'(v[1]),   32'd1);
        check("t2_ovf",   32'(v[3]),   32'd1);

        // STATUS store without bit 3 leaves overflow alone; with bit 3 clears it
        step(1'b1, STATA, 32'hFFFF_FFF7);
        peek_status(v);
        check("t4_ovf_kept", 32'(v[3]), 32'd1);
        step(1'b1, STATA, 32'h0000_0008);
        peek_status(v);
        check("t4_ovf_clear", 32'(v[3]),   32'd0);
        check("t4_count",     32'(v[8:4]), 32'd8);
        check("t4_full",      32'(v[1]),   32'd1);

        // Store into a full FIFO exactly on the pop cycle
        guard = 0;
        while (!(m_busy == 0 && m_q.size() > 0) && guard < 200) begin
            step(1'b0, STATA, 32'd0);
            guard++;
        end
        check("t3_wait_timeout", 32'(guard < 200), 32'd1);
        step(1'b1, BASE, 32'h0000_003A);
        peek_status(v);
        check("t3_count", 32'(v[8:4]), 32'd8);
        check("t3_ovf",   32'(v[3]),   32'd0);
        drain();

        // Halt
        step(1'b1, HALTA, 32'h0000_0155);
        check("t5_halt", 32'(halt),      32'd1);
        check("t5_code", 32'(exit_code), 32'h55);
        step(1'b1, HALTA, 32'h0000_0077);
        check("t5_code_sticky", 32'(exit_code), 32'h55);
        step(1'b1, BASE, 32'h0000_0042);
        drain();

        // Randomised traffic
        repeat (500) begin
            r  = $urandom_range(0, 99);
            d  = $urandom;
            we = 1'b1;
            if (r < 30) begin
                a = BASE | 32'($urandom_range(0, 3));
            end else if (r < 36) begin
                a = STATA | 32'($urandom_range(0, 3));
            end else if (r < 39) begin
                a = HALTA;
            end else if (r < 45) begin
                a = $urandom;
            end else if (r < 50) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'd8 : BASE - 32'd4;
            end else begin
                we = 1'b0;
                case ($urandom_range(0, 2))
                    0:       a = BASE;
                    1:       a = STATA;
                    default: a = $urandom;
                endcase
            end
            step(we, a, d);
        end
        drain();

        // Reset in the middle of a frame's data bits
        step(1'b1, BASE, 32'h0000_00A0);
        guard = 0;
        while (m_busy != 6 * CPB && guard < 200) begin
            step(1'b0, STATA, 32'd0);
            guard++;
        end
        check("t6_wait_timeout", 32'(guard < 200), 32'd1);
        check("t6_line_low", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_uart_tx", 32'(uart_tx), 32'd1);
        peek_status(v);
        check("t6_status", v, 32'h0000_0001);
        check("t6_halt",   32'(halt), 32'd0);
        step(1'b0, STATA, 32'd0);
        step(1'b0, STATA, 32'd0);
        reset = 1'b0;
        step(1'b1, BASE, 32'h0000_003C);
        drain();

        check("frames_outstanding", 32'(exp_frames.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
